// File: rtl/psum_normalizer_pkg.sv
// Shared constants, FSM state type and helpers for the partial-sum normalizer.
// The divider and the top level both import this package.
package psum_norm_pkg;

  localparam int COL     = 8;
  localparam int BW_PSUM = 20;
  localparam int BW_SUM  = BW_PSUM + 4;
  localparam int BW_OUT  = 8;
  localparam int FRAC    = BW_OUT - 1;
  localparam int ELEM_W  = $clog2(COL);

  // Largest representable positive fraction; a full-scale quotient of 2^FRAC clips here.
  localparam logic [BW_OUT-1:0] SAT_LIM = BW_OUT'((1 << FRAC) - 1);

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    WAIT,
    DIV,
    OUT
  } state_e;

  // Magnitude of a signed psum as an unsigned value of the same width; -2^(n-1) maps to 2^(n-1).
  function automatic logic [BW_PSUM-1:0] abs_psum(input logic signed [BW_PSUM-1:0] v);
    logic [BW_PSUM-1:0] u;
    u = v;
    return v[BW_PSUM-1] ? (~u + 1'b1) : u;
  endfunction

endpackage

// File: rtl/psum_normalizer_if.sv
// Vector, partner-sum and result handshake bundle of one normalizer instance.
// slave is the normalizer side; master is the surrounding array / consumer side.
interface psum_normalizer_if;
  import psum_norm_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [BW_PSUM*COL-1:0]    psum_in;
  logic [BW_SUM-1:0]         sum_local_out;
  logic                      sum_local_valid;
  logic [BW_SUM-1:0]         sum_partner;
  logic                      sum_partner_valid;
  logic [BW_OUT*COL-1:0]     norm_out;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_valid, psum_in, sum_partner, sum_partner_valid, out_ready,
    output in_ready, sum_local_out, sum_local_valid, norm_out, out_valid
  );

  modport master (
    output in_valid, psum_in, sum_partner, sum_partner_valid, out_ready,
    input  in_ready, sum_local_out, sum_local_valid, norm_out, out_valid
  );

endinterface

// File: rtl/psum_div_serial.sv
// Restoring divider producing floor(dividend * 2^FRAC / divisor), one quotient bit per cycle.
// The start cycle already resolves the MSB, so a result is ready after exactly BW_OUT cycles.
module psum_div_serial
  import psum_norm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [BW_PSUM-1:0] dividend_i,
  input  logic [BW_SUM-1:0]  divisor_i,
  output logic [BW_OUT-1:0]  quotient_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(BW_OUT);

  logic              busy_q, busy_d;
  logic [BW_SUM:0]   rem_q, rem_d;
  logic [BW_OUT-2:0] quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              active;
  logic              bit_v;
  logic [BW_SUM:0]   rem_cur;
  logic [BW_SUM:0]   rem_sub;
  logic [BW_OUT-1:0] quo_full;
  logic [CNT_W-1:0]  cnt_cur;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    active   = start_i | busy_q;
    rem_cur  = start_i ? (BW_SUM+1)'(dividend_i) : rem_q;
    cnt_cur  = start_i ? '0 : cnt_q;
    bit_v    = rem_cur >= {1'b0, divisor_i};
    rem_sub  = bit_v ? (rem_cur - {1'b0, divisor_i}) : rem_cur;
    quo_full = {(start_i ? (BW_OUT-1)'(0) : quo_q), bit_v};
    done_o   = active && (cnt_cur == CNT_W'(BW_OUT - 1));
    quotient_o = (quo_full > SAT_LIM) ? SAT_LIM : quo_full;

    busy_d = busy_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    if (active) begin
      busy_d = !done_o;
      rem_d  = rem_sub << 1;
      quo_d  = quo_full[BW_OUT-2:0];
      cnt_d  = cnt_cur + 1'b1;
    end
  end

  assign busy_o = busy_q;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/psum_normalizer.sv
// Normalizes one core's psum vector by the combined |psum| total of both cores.
// Exports the local sum, waits for the partner's, then divides element by element.
module psum_normalizer
  import psum_norm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  psum_normalizer_if.slave   bus
);

  state_e                      state_q, state_d;
  logic signed [BW_PSUM-1:0]   psum_q [COL];
  logic signed [BW_PSUM-1:0]   psum_d [COL];
  logic [BW_SUM-1:0]           local_q, local_d;
  logic [BW_SUM-1:0]           total_q, total_d;
  logic [ELEM_W-1:0]           elem_q, elem_d;
  logic [BW_OUT*COL-1:0]       res_q, res_d;
  logic [BW_OUT*COL-1:0]       norm_q, norm_d;

  logic [BW_SUM-1:0]  local_sum;
  logic [BW_SUM-1:0]  total_sum;
  logic               div_start;
  logic               div_done;
  logic               div_busy;
  logic [BW_OUT-1:0]  div_quo;
  logic [BW_OUT-1:0]  elem_val;

  always_comb begin
    local_sum = '0;
    for (int k = 0; k < COL; k++) begin
      local_sum = local_sum + BW_SUM'(abs_psum(psum_q[k]));
    end
  end

  assign total_sum = local_q + bus.sum_partner;
  assign div_start = (state_q == DIV) && !div_busy;
  assign elem_val  = psum_q[elem_q][BW_PSUM-1] ? (~div_quo + 1'b1) : div_quo;

  psum_div_serial u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (abs_psum(psum_q[elem_q])),
    .divisor_i  (total_q),
    .quotient_o (div_quo),
    .done_o     (div_done),
    .busy_o     (div_busy)
  );

  always_comb begin
    state_d = state_q;
    psum_d  = psum_q;
    local_d = local_q;
    total_d = total_q;
    elem_d  = elem_q;
    res_d   = res_q;
    norm_d  = norm_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int k = 0; k < COL; k++) begin
            psum_d[k] = bus.psum_in[k*BW_PSUM +: BW_PSUM];
          end
          state_d = SUM;
        end
      end
      SUM: begin
        local_d = local_sum;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.sum_partner_valid) begin
          total_d = total_sum;
          elem_d  = '0;
          if (total_sum == '0) begin
            norm_d  = '0;
            state_d = OUT;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          res_d[elem_q*BW_OUT +: BW_OUT] = elem_val;
          if (elem_q == ELEM_W'(COL - 1)) begin
            norm_d  = res_d;
            state_d = OUT;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      local_q <= '0;
      total_q <= '0;
      elem_q  <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      local_q <= local_d;
      total_q <= total_d;
      elem_q  <= elem_d;
      norm_q  <= norm_d;
    end
  end

  // NOTE: the psum latch and result scratch are pure data storage, fully rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    psum_q <= psum_d;
    res_q  <= res_d;
  end

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.sum_local_valid = (state_q == WAIT);
  assign bus.sum_local_out   = local_q;
  assign bus.out_valid       = (state_q == OUT);
  assign bus.norm_out        = norm_q;

endmodule
